// File: rtl/stream_reduction_unit_if.sv
// Handshake bundle between a word-stream producer and the frame reduction unit.
// The master modport is the producer/consumer side; the slave modport is the reduction unit.
interface stream_reduction_unit_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
);
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [2:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;
    logic [CW-1:0]    out_count;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_count, out_ovf, out_err
    );

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_result, out_count, out_ovf, out_err
    );
endinterface

// File: rtl/stream_reduction_unit.sv
// Reduces a multi-beat frame of words to a single bit (AND/OR/XOR and their inversions),
// reporting the saturating beat count, an overflow flag and an illegal-mode flag.
module stream_reduction_unit #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_reduction_unit_if.slave bus
);
    localparam int            CW      = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [2:0]    r_modeQ;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_result;
    logic [CW-1:0] r_countOut;
    logic          r_ovfOut;
    logic          r_err;

    logic          w_inReady;
    logic          w_outValid;
    logic          w_accept;
    logic [2:0]    w_modeEff;
    logic [1:0]    w_family;
    logic          w_wordRed;
    logic          w_accNext;
    logic [CW-1:0] w_cntNext;
    logic          w_ovfNext;
    logic          w_resultFinal;
    logic          w_errFinal;

    // Modes share a base operator by residue mod 3; 6 and 7 fall into the AND/OR families.
    function automatic logic [1:0] familyOf(input logic [2:0] m);
        logic [1:0] fam;
        case (m)
            3'd0, 3'd3, 3'd6: fam = 2'd0;
            3'd1, 3'd4, 3'd7: fam = 2'd1;
            default:          fam = 2'd2;
        endcase
        return fam;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = (r_state != HOLD);
        w_outValid  = (r_state == HOLD);
        w_accept    = bus.in_valid & w_inReady;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && bus.in_last) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Mode is taken live on the first beat and from the latched copy for the rest of the frame.
    always_comb begin
        w_modeEff = (r_state == IDLE) ? bus.mode : r_modeQ;
        w_family  = familyOf(w_modeEff);
        case (w_family)
            2'd0:    w_wordRed = &bus.in_data;
            2'd1:    w_wordRed = |bus.in_data;
            default: w_wordRed = ^bus.in_data;
        endcase

        w_accNext = w_wordRed;
        w_cntNext = CW'(1);
        w_ovfNext = 1'b0;
        if (r_state != IDLE) begin
            case (w_family)
                2'd0:    w_accNext = r_acc & w_wordRed;
                2'd1:    w_accNext = r_acc | w_wordRed;
                default: w_accNext = r_acc ^ w_wordRed;
            endcase
            w_cntNext = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + CW'(1);
            w_ovfNext = r_ovf | (r_cnt == MAX_CNT);
        end

        w_errFinal = (w_modeEff >= 3'd6);
        if (w_errFinal) begin
            w_resultFinal = 1'b0;
        end else if (w_modeEff >= 3'd3) begin
            w_resultFinal = ~w_accNext;
        end else begin
            w_resultFinal = w_accNext;
        end
    end

    // Reported values load only with the last beat, so they stay put until the next frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_modeQ    <= 3'd0;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_result   <= 1'b0;
            r_countOut <= '0;
            r_ovfOut   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_accNext;
            r_cnt <= w_cntNext;
            r_ovf <= w_ovfNext;
            if (r_state == IDLE) begin
                r_modeQ <= bus.mode;
            end
            if (bus.in_last) begin
                r_result   <= w_resultFinal;
                r_countOut <= w_cntNext;
                r_ovfOut   <= w_ovfNext;
                r_err      <= w_errFinal;
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = w_outValid;
    assign bus.out_result = r_result;
    assign bus.out_count  = r_countOut;
    assign bus.out_ovf    = r_ovfOut;
    assign bus.out_err    = r_err;
endmodule

// File: tb/tb_stream_reduction_unit.sv
// Self-checking bench for stream_reduction_unit: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_stream_reduction_unit;
    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [WIDTH-1:0] frameWords [0:15];

    stream_reduction_unit_if #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();

    stream_reduction_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Frame-level model: each word collapses to one bit, then the frame is all/any/parity of those bits.
    function automatic logic modelResult(input logic [2:0] m, input int len);
        int   fam;
        logic allOnes;
        logic anyOne;
        logic parity;
        logic b;
        logic acc;
        fam     = int'(m) % 3;
        allOnes = 1'b1;
        anyOne  = 1'b0;
        parity  = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (fam == 0)      b = (frameWords[i] == {WIDTH{1'b1}});
            else if (fam == 1) b = (frameWords[i] != '0);
            else               b = ^frameWords[i];
            allOnes = allOnes & b;
            anyOne  = anyOne | b;
            parity  = parity ^ b;
        end
        acc = (fam == 0) ? allOnes : (fam == 1) ? anyOne : parity;
        if (m >= 3'd6) return 1'b0;
        if (m >= 3'd3) return ~acc;
        return acc;
    endfunction

    // Called at a negedge; returns at the negedge after the final beat is accepted.
    task automatic sendBeats(input logic [2:0] m, input int len, input bit markLast, input logic [2:0] midMode);
        int waitCnt;
        for (int i = 0; i < len; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = frameWords[i];
            bus.in_last  = markLast && (i == len - 1);
            bus.mode     = (i == 0) ? m : midMode;
            waitCnt = 0;
            while (!bus.in_ready && waitCnt < 20) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!bus.in_ready) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] m, input int len, input logic [2:0] midMode, input int holdCycles);
        logic expResult;
        int   expCount;
        expResult = modelResult(m, len);
        expCount  = (len > MAX_BEATS) ? MAX_BEATS : len;
        sendBeats(m, len, 1'b1, midMode);
        checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("result", 32'(bus.out_result), 32'(expResult));
        checkOutput("count", 32'(bus.out_count), 32'(expCount));
        checkOutput("ovf", 32'(bus.out_ovf), 32'(len > MAX_BEATS));
        checkOutput("err", 32'(bus.out_err), 32'(m >= 3'd6));
        for (int k = 0; k < holdCycles; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
            checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("bp_result", 32'(bus.out_result), 32'(expResult));
            checkOutput("bp_count", 32'(bus.out_count), 32'(expCount));
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic setWords(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2);
        frameWords[0] = w0;
        frameWords[1] = w1;
        frameWords[2] = w2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        logic [2:0] m;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.mode      = 3'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) frameWords[i] = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_result", 32'(bus.out_result), 32'd0);
        checkOutput("rst_count", 32'(bus.out_count), 32'd0);
        checkOutput("rst_ovf", 32'(bus.out_ovf), 32'd0);
        checkOutput("rst_err", 32'(bus.out_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset mid-frame");
        setWords(8'hA5, 8'h3C, 8'hFF);
        sendBeats(3'd2, 3, 1'b0, 3'd2);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frameWords[0] = 8'h01;
        applyStimulus(3'd2, 1, 3'd2, 0);
        checkOutput("dir_xor_single", 32'(bus.out_result), 32'd1);
        checkOutput("dir_single_count", 32'(bus.out_count), 32'd1);

        $display("[TB] directed reductions");
        setWords(8'hFF, 8'hFF, 8'hFE);
        applyStimulus(3'd0, 3, 3'd0, 0);
        checkOutput("dir_and", 32'(bus.out_result), 32'd0);
        checkOutput("dir_and_count", 32'(bus.out_count), 32'd3);
        applyStimulus(3'd3, 3, 3'd3, 0);
        checkOutput("dir_nand", 32'(bus.out_result), 32'd1);
        setWords(8'h03, 8'h01, 8'h00);
        applyStimulus(3'd2, 2, 3'd2, 0);
        checkOutput("dir_xor", 32'(bus.out_result), 32'd1);
        applyStimulus(3'd5, 2, 3'd5, 0);
        checkOutput("dir_xnor", 32'(bus.out_result), 32'd0);
        setWords(8'h00, 8'h00, 8'h10);
        applyStimulus(3'd1, 3, 3'd1, 0);
        checkOutput("dir_or", 32'(bus.out_result), 32'd1);
        applyStimulus(3'd4, 3, 3'd4, 5);
        checkOutput("dir_nor", 32'(bus.out_result), 32'd0);

        $display("[TB] overflow with mid-frame mode change");
        for (int i = 0; i < 6; i++) frameWords[i] = 8'h00;
        frameWords[2] = 8'h01;
        applyStimulus(3'd1, 6, 3'd0, 1);
        checkOutput("dir_ovf_result", 32'(bus.out_result), 32'd1);
        checkOutput("dir_ovf_count", 32'(bus.out_count), 32'd4);
        checkOutput("dir_ovf_flag", 32'(bus.out_ovf), 32'd1);

        $display("[TB] illegal mode");
        setWords(8'hFF, 8'hFF, 8'h00);
        applyStimulus(3'd7, 2, 3'd7, 0);
        checkOutput("dir_err", 32'(bus.out_err), 32'd1);
        checkOutput("dir_err_result", 32'(bus.out_result), 32'd0);
        applyStimulus(3'd0, 2, 3'd0, 0);
        checkOutput("dir_err_clear", 32'(bus.out_err), 32'd0);
        checkOutput("dir_after_err", 32'(bus.out_result), 32'd1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 7);
            m   = 3'($urandom_range(0, 7));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       frameWords[i] = 8'hFF;
                    1:       frameWords[i] = 8'h00;
                    default: frameWords[i] = 8'($urandom);
                endcase
            end
            applyStimulus(m, len, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
